// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - PC register, IF/ID capture, stall/flush/branch/halt control.
// Optional perf counters (fetch_count, bubble_count) when INSTR_FETCH_PERF_EN is defined.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted,
  output logic        misalign_err
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;
  logic        br_misaligned;

  assign pc_inc        = (pc + 32'd4) & PC_MASK;
  assign br_pc         = {branch_target[31:2], 2'b00} & PC_MASK;
  assign br_misaligned = |branch_target[1:0];
  assign imem_addr     = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_instr     <= NOP_WORD;
      if_pc        <= 32'd0;
      if_pc_plus4  <= 32'd0;
      if_valid     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if_instr <= NOP_WORD;
          if_valid <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            pc       <= br_pc;
            if_instr <= NOP_WORD;
            if_valid <= 1'b0;
            if (br_misaligned) misalign_err <= 1'b1;
          end else if (flush) begin
            if (!stall) pc <= pc_inc;
            if_instr <= NOP_WORD;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_pc_plus4 <= pc_inc;
            if_valid    <= 1'b1;
            // The halt word is delivered with valid=1, but pc stays on it.
            if (imem_data == HALT_WORD) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
        end
        HALT: begin
          if_instr <= NOP_WORD;
          if_valid <= 1'b0;
          if (branch_taken) begin
            pc     <= br_pc;
            halted <= 1'b0;
            state  <= RUN;
            if (br_misaligned) misalign_err <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic do_fetch;
  logic do_bubble;

  assign do_fetch  = (state == RUN) && !branch_taken && !flush && !stall;
  assign do_bubble = (state == BOOT) || ((state == RUN) && (branch_taken || flush));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (do_fetch)  fetch_count  <= fetch_count + 32'd1;
      if (do_bubble) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized bench for instr_fetch_stage against a behavioural model.
module tb_instr_fetch_stage;
  localparam int          MB   = 128;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] imem_addr, imem_data, if_instr, if_pc, if_pc_plus4;
  logic        if_valid, halted, misalign_err;

  logic [31:0] mem [0:MB/4-1];

  int total = 0;
  int bad = 0;
  bit check_en = 0;

  // model: fetch mode 0=booting, 1=running, 2=halted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
  bit          m_v, m_h, m_mis;

  instr_fetch_stage #(
    .RESET_PC (32'h0), .MEM_BYTES(MB), .NOP_WORD(NOP), .HALT_WORD(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_valid(if_valid), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[6:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 0; m_instr = NOP; m_ipc = 0; m_ip4 = 0;
      m_v = 0; m_h = 0; m_mis = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      m_instr = NOP; m_v = 0; m_mode = 1;
    end else if (m_mode == 2) begin
      m_instr = NOP; m_v = 0;
      if (branch_taken) begin
        m_pc = ((branch_target / 4) * 4) % MB;
        if (branch_target % 4 != 0) m_mis = 1;
        m_h = 0; m_mode = 1;
      end
    end else if (branch_taken) begin
      m_pc = ((branch_target / 4) * 4) % MB;
      if (branch_target % 4 != 0) m_mis = 1;
      m_instr = NOP; m_v = 0;
    end else if (flush) begin
      if (!stall) m_pc = (m_pc + 4) % MB;
      m_instr = NOP; m_v = 0;
    end else if (!stall) begin
      w = mem[(m_pc / 4) % (MB / 4)];
      m_instr = w; m_ipc = m_pc; m_ip4 = (m_pc + 4) % MB; m_v = 1;
      if (w == HALT) begin
        m_mode = 2; m_h = 1;
      end else begin
        m_pc = (m_pc + 4) % MB;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit b, input logic [31:0] t);
    rst_n = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_update();
    check_en = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
      chk("if_pc_plus4", if_pc_plus4, m_ip4);
      chk("if_valid", 32'(if_valid), 32'(m_v));
      chk("halted", 32'(halted), 32'(m_h));
      chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
  end

  initial begin
    for (int i = 0; i < MB / 4; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;

    step(0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 0, 32'd0);
    chk("lit_rst_addr", imem_addr, 32'h0);
    chk("lit_rst_valid", 32'(if_valid), 32'h0);
    idle();
    chk("lit_boot_valid", 32'(if_valid), 32'h0);
    idle();
    chk("lit_w0", if_instr, 32'h1000_0000);
    chk("lit_w0_pc", if_pc, 32'h0);
    idle();
    chk("lit_w1", if_instr, 32'h1000_0101);
    chk("lit_w1_addr", imem_addr, 32'h8);
    repeat (3) begin
      step(1, 1, 0, 0, 32'd0);
      chk("lit_stall_pc", if_pc, 32'h4);
      chk("lit_stall_addr", imem_addr, 32'h8);
    end
    idle();
    chk("lit_w2", if_instr, 32'h1000_0202);

    step(1, 1, 0, 1, 32'h40);
    chk("lit_br_valid", 32'(if_valid), 32'h0);
    chk("lit_br_addr", imem_addr, 32'h40);
    idle();
    chk("lit_br_pc", if_pc, 32'h40);
    chk("lit_br_mis", 32'(misalign_err), 32'h0);

    step(1, 0, 0, 1, 32'h0000_0103);
    chk("lit_mis_addr", imem_addr, 32'h0);
    chk("lit_mis_set", 32'(misalign_err), 32'h1);
    repeat (3) idle();
    chk("lit_mis_sticky", 32'(misalign_err), 32'h1);

    step(1, 0, 0, 1, 32'h7C);
    idle();
    chk("lit_wrap_pc", if_pc, 32'h7C);
    chk("lit_wrap_p4", if_pc_plus4, 32'h0);
    chk("lit_wrap_addr", imem_addr, 32'h0);

    mem[4] = HALT;
    step(0, 0, 0, 0, 32'd0);
    idle();
    repeat (5) idle();
    chk("lit_halt_instr", if_instr, HALT);
    chk("lit_halt_valid", 32'(if_valid), 32'h1);
    chk("lit_halt_flag", 32'(halted), 32'h1);
    chk("lit_halt_addr", imem_addr, 32'h10);
    idle();
    chk("lit_halt_hold", imem_addr, 32'h10);
    step(1, 0, 0, 1, 32'h0);
    chk("lit_resume_flag", 32'(halted), 32'h0);
    idle();
    chk("lit_resume_w0", if_instr, 32'h1000_0000);
    repeat (4) idle();
    chk("lit_halt2", 32'(halted), 32'h1);
    step(0, 0, 0, 0, 32'd0);
    chk("lit_rst_halt", 32'(halted), 32'h0);
    chk("lit_rst_instr", if_instr, NOP);
    chk("lit_rst_pc", if_pc, 32'h0);

    for (int i = 0; i < MB / 4; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] t;
      if ($urandom_range(0, 7) == 0)
        mem[$urandom_range(0, MB / 4 - 1)] = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h1FF);
      if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 59) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
